// File: rtl/circuit5_seq_ctrl.sv
// circuit5_seq_ctrl: multi-cycle sequencer for the circuit5 function.
// d = a+b, e = a+c and f = a-b are computed one per cycle on a single
// shared adder/subtractor. One signed comparator then yields lt/eq, which
// select g/h and the 0/1-bit shifts that form x and z.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and the result stays stable until the edge where out_ready is high. Neither
// ready depends combinationally on the other side's valid.
module circuit5_seq_ctrl #(
    parameter int DATAW = 64,
    parameter int OUTW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    input  logic [DATAW-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUTW-1:0]  x,
    output logic [OUTW-1:0]  z,
    output logic             lt_flag,
    output logic             eq_flag,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_D = 3'd1,
        CALC_E = 3'd2,
        CALC_F = 3'd3,
        CMP    = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state;
    logic [DATAW-1:0] a_r, b_r, c_r;
    logic [DATAW-1:0] d_r, e_r, f_r, g_r, h_r;
    logic             lt_r, eq_r;

    logic [DATAW-1:0] add_rhs;
    logic             add_sub;
    logic [DATAW-1:0] add_res;
    logic             cmp_lt, cmp_eq;
    logic [DATAW-1:0] g_next, h_next;
    logic [DATAW-1:0] h_sh, g_sh;
    logic             unused_bits;

    // Shared adder/subtractor: operand and mode are picked by the current state.
    always_comb begin
        add_rhs = b_r;
        add_sub = 1'b0;
        case (state)
            CALC_E:  add_rhs = c_r;
            CALC_F:  add_sub = 1'b1;
            default: ;
        endcase
        add_res = a_r + (add_sub ? ~add_rhs : add_rhs)
                + {{(DATAW-1){1'b0}}, add_sub};
    end

    // Single signed comparator on the wrapped d/e, plus the g/h selection.
    always_comb begin
        cmp_lt = $signed(d_r) < $signed(e_r);
        cmp_eq = (d_r == e_r);
        g_next = cmp_lt ? e_r : d_r;
        h_next = cmp_eq ? f_r : g_next;
    end

    // 0/1-bit shifters: left shift of h by lt, arithmetic right shift of g by eq.
    always_comb begin
        h_sh = lt_r ? {h_r[DATAW-2:0], 1'b0} : h_r;
        g_sh = eq_r ? {g_r[DATAW-1], g_r[DATAW-1:1]} : g_r;
    end

    // Bits above OUTW are truncated away by design.
    assign unused_bits = ^{h_sh, g_sh};

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Sequencer: walks the datapath one operation per cycle and holds the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            d_r       <= '0;
            e_r       <= '0;
            f_r       <= '0;
            g_r       <= '0;
            h_r       <= '0;
            lt_r      <= 1'b0;
            eq_r      <= 1'b0;
            x         <= '0;
            z         <= '0;
            lt_flag   <= 1'b0;
            eq_flag   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        c_r   <= c;
                        state <= CALC_D;
                    end
                end
                CALC_D: begin
                    d_r   <= add_res;
                    state <= CALC_E;
                end
                CALC_E: begin
                    e_r   <= add_res;
                    state <= CALC_F;
                end
                CALC_F: begin
                    f_r   <= add_res;
                    state <= CMP;
                end
                CMP: begin
                    lt_r  <= cmp_lt;
                    eq_r  <= cmp_eq;
                    g_r   <= g_next;
                    h_r   <= h_next;
                    state <= SHIFT;
                end
                SHIFT: begin
                    x         <= h_sh[OUTW-1:0];
                    z         <= g_sh[OUTW-1:0];
                    lt_flag   <= lt_r;
                    eq_flag   <= eq_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circuit5_seq_ctrl.sv
// Testbench for circuit5_seq_ctrl: directed spec cases, randomized operands
// against a behavioural model, backpressure, mid-operation reset and
// back-to-back throughput.
module tb_circuit5_seq_ctrl;

    localparam int DATAW = 64;
    localparam int OUTW  = 32;
    localparam int W     = 2 * OUTW + 2;

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] a, b, c;
    logic             out_valid;
    logic             out_ready;
    logic [OUTW-1:0]  x, z;
    logic             lt_flag, eq_flag, busy;
    logic [2:0]       state_dbg;

    circuit5_seq_ctrl #(.DATAW(DATAW), .OUTW(OUTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .z(z), .lt_flag(lt_flag), .eq_flag(eq_flag), .busy(busy),
        .state_dbg(state_dbg)
    );

    // scoreboard: {lt, eq, z, x}
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // reference model straight from the function definition
    function automatic logic [W-1:0] model(input logic [DATAW-1:0] av, bv, cv);
        logic [DATAW-1:0] d, e, f, g, h, xs, zs;
        logic lt, eq;
        d  = av + bv;
        e  = av + cv;
        f  = av - bv;
        lt = $signed(d) < $signed(e);
        eq = (d == e);
        g  = lt ? e : d;
        h  = eq ? f : g;
        xs = h << lt;
        zs = $signed(g) >>> eq;
        return {lt, eq, zs[OUTW-1:0], xs[OUTW-1:0]};
    endfunction

    // driver: present operands once in_ready is seen, return accept cycle
    task automatic issue(input logic [DATAW-1:0] av, bv, cv, output int acc_cyc);
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        a = av; b = bv; c = cv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL accept: busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
        end
    endtask

    // wait for result, check latency and value, then release it
    task automatic collect(input bit rand_ready);
        int lat = 0;
        logic [W-1:0] e, got;
        while (out_valid !== 1'b1 && lat < 20) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency: edges=%0d required 5", lat);
        end
        got = {lt_flag, eq_flag, z, x};
        e = '0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got=%h required an expected entry", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL result: got lt=%b eq=%b z=%h x=%h required lt=%b eq=%b z=%h x=%h",
                         got[W-1], got[W-2], got[2*OUTW-1:OUTW], got[OUTW-1:0],
                         e[W-1], e[W-2], e[2*OUTW-1:OUTW], e[OUTW-1:0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
        checks++;
        if ({lt_flag, eq_flag, z, x} !== e) begin
            failures++;
            $display("FAIL held_in_idle: got=%h required %h", {lt_flag, eq_flag, z, x}, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        checks++;
        if (x !== '0 || z !== '0 || lt_flag !== 1'b0 || eq_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: x=%h z=%h lt=%b eq=%b required all 0", x, z, lt_flag, eq_flag);
        end
    endtask

    task automatic run_directed(input logic [DATAW-1:0] av, bv, cv, input logic [W-1:0] exp);
        int t;
        issue(av, bv, cv, t);
        exp_q.push_back(exp);
        collect(1'b0);
    endtask

    task automatic test_directed();
        run_directed(64'd10, 64'd3, 64'd5, {1'b1, 1'b0, 32'd15, 32'd30});
        run_directed(64'd10, 64'd5, 64'd5, {1'b0, 1'b1, 32'd7, 32'd5});
        run_directed(64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8,
                     {1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008});
        run_directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
                     {1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    endtask

    task automatic test_random();
        logic [DATAW-1:0] av, bv, cv;
        int t;
        for (int i = 0; i < 40; i++) begin
            av = {$urandom(), $urandom()};
            bv = {$urandom(), $urandom()};
            cv = ($urandom_range(0, 3) == 0) ? bv : {$urandom(), $urandom()};
            if ($urandom_range(0, 4) == 0) av = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            issue(av, bv, cv, t);
            exp_q.push_back(model(av, bv, cv));
            collect(1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [DATAW-1:0] av, bv, cv;
        logic [W-1:0] e, snap;
        int t;
        int w = 0;
        av = {$urandom(), $urandom()};
        bv = {$urandom(), $urandom()};
        cv = {$urandom(), $urandom()};
        e = model(av, bv, cv);
        issue(av, bv, cv, t);
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        snap = {lt_flag, eq_flag, z, x};
        checks++;
        if (out_valid !== 1'b1 || snap !== e) begin
            failures++;
            $display("FAIL bp_first: out_valid=%b got=%h required 1 %h", out_valid, snap, e);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            c = {$urandom(), $urandom()};
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {lt_flag, eq_flag, z, x} !== snap) begin
                failures++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b got=%h required 1 0 %h",
                         out_valid, in_ready, {lt_flag, eq_flag, z, x}, snap);
            end
        end
        // in_valid stays high across the release edge: must not be accepted there
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        av = {$urandom(), $urandom()};
        bv = {$urandom(), $urandom()};
        cv = bv;
        issue(av, bv, cv, t);
        exp_q.push_back(model(av, bv, cv));
        collect(1'b0);
    endtask

    task automatic test_reset_mid();
        int t;
        bit seen = 1'b0;
        issue(64'd77, 64'd12, 64'd99, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ctrl: busy=%b out_valid=%b in_ready=%b required 0 0 1",
                     busy, out_valid, in_ready);
        end
        checks++;
        if (x !== '0 || z !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: x=%h z=%h required 0 0", x, z);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midreset_no_result: activity seen=1 required 0");
        end
        run_directed(64'd10, 64'd3, 64'd5, {1'b1, 1'b0, 32'd15, 32'd30});
    endtask

    task automatic test_back_to_back();
        logic [DATAW-1:0] av, bv, cv;
        int t, prev;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            av = {$urandom(), $urandom()};
            bv = {$urandom(), $urandom()};
            cv = (i % 2 == 0) ? bv : {$urandom(), $urandom()};
            issue(av, bv, cv, t);
            if (prev >= 0) begin
                checks++;
                if (t - prev != 7) begin
                    failures++;
                    $display("FAIL b2b_spacing: cycles=%0d required 7", t - prev);
                end
            end
            prev = t;
            exp_q.push_back(model(av, bv, cv));
            collect(1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; c = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
